// File: rtl/render_arbiter.sv
// Round-robin owner of the single VGA framebuffer write port, shared by up to four render engines.
// Optional watchdog on the done handshake is built when RENDER_ARB_TIMEOUT_EN is defined.
module render_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  done,
  input  logic [35:0] eng_x,
  input  logic [31:0] eng_y,
  input  logic [3:0]  eng_colour,
  input  logic [3:0]  eng_we,
  output logic [3:0]  start,
  output logic [3:0]  grant,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic        vga_colour,
  output logic        vga_we,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [1:0]  cand;
  logic [1:0]  pick_idx;
  logic        pick_valid;
  logic        timeout_hit;

  // First requester at or after last+1, wrapping modulo 4.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef RENDER_ARB_TIMEOUT_EN
  logic [9:0] cnt_q, cnt_d;
  logic       timeout_err_q, timeout_err_d;

  always_comb begin
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    timeout_hit   = 1'b0;
    if (state_q == S_START) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + 10'd1;
      if (!done[owner_q] && cnt_d == 10'(TIMEOUT_CYCLES)) begin
        timeout_hit   = 1'b1;
        timeout_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^10'(TIMEOUT_CYCLES);
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = 4'b0001 << pick_idx;
          owner_d = pick_idx;
          state_d = S_START;
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (done[owner_q] || timeout_hit) begin
          grant_d = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign grant  = grant_q;
  assign start  = (state_q == S_START) ? grant_q : '0;
  assign busy   = (state_q != S_IDLE);
  assign vga_we = ((state_q == S_START) || (state_q == S_WAIT)) && eng_we[owner_q];

  always_comb begin
    vga_x      = eng_x[8:0];
    vga_y      = eng_y[7:0];
    vga_colour = eng_colour[0];
    case (owner_q)
      2'd1: begin vga_x = eng_x[17:9];  vga_y = eng_y[15:8];  vga_colour = eng_colour[1]; end
      2'd2: begin vga_x = eng_x[26:18]; vga_y = eng_y[23:16]; vga_colour = eng_colour[2]; end
      2'd3: begin vga_x = eng_x[35:27]; vga_y = eng_y[31:24]; vga_colour = eng_colour[3]; end
      default: ;
    endcase
  end

endmodule

// File: doc/render_arbiter.md
# render_arbiter

Round-robin scheduler that shares the single VGA framebuffer write port between up to four render engines: box cursor, piece sprite, board fill and status text. It runs a start/complete handshake with each engine and forwards only the granted engine's pixel stream to the `vga_adapter` write port. It also blocks writes from idle or non-granted engines, whose `writeEn` may be high while they are idle.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1023: watchdog limit while waiting for `done`. Used only with `RENDER_ARB_TIMEOUT_EN`. Legal range is 1 to 1023.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `req`  in  4: per-engine request, level. Engine i holds it high until it sees `start[i]`.
- `done`  in  4: per-engine completion pulse, one cycle.
- `eng_x`  in  36: packed x coordinates; engine i uses `[9i+8:9i]`.
- `eng_y`  in  32: packed y coordinates; engine i uses `[8i+7:8i]`.
- `eng_colour`  in  4: per-engine colour bit.
- `eng_we`  in  4: per-engine write enable.
- `start`  out  4: one-cycle start pulse to the granted engine.
- `grant`  out  4: one-hot owner of the port, or 0 when no owner.
- `vga_x`  out  9: x to the framebuffer port.
- `vga_y`  out  8: y to the framebuffer port.
- `vga_colour`  out  1: colour to the framebuffer port.
- `vga_we`  out  1: write enable to the framebuffer port.
- `busy`  out  1: high whenever the state is not `S_IDLE`.
- `timeout_err`  out  1: sticky watchdog flag. Tied to 0 without the macro.

## Operation
- State machine: `S_IDLE` → `S_START` → `S_WAIT` → `S_RELEASE` → `S_IDLE`.
- `S_IDLE`:
  - If `req` is nonzero, pick the first set bit searching upward from `last+1` (mod 4).
  - Register the winner into `grant` (one-hot) and the 2-bit `owner`, then go to `S_START`.
  - If `req` is 0, stay in `S_IDLE`.
- `S_START`: `start = grant` for exactly this cycle, then go to `S_WAIT`.
- `S_WAIT`:
  - Stay until `done[owner]` is 1, then go to `S_RELEASE`.
  - `done` bits from non-owners are ignored.
  - `done[owner]` arriving during `S_START` is ignored.
- `S_RELEASE`:
  - `grant` is 0; load `last <= owner`.
  - Go to `S_IDLE`. This dead cycle lets the finished engine settle.
- Output mux:
  - `vga_x`, `vga_y` and `vga_colour` select `owner`'s slice at all times.
  - `vga_we = eng_we[owner]`, but only in `S_START` or `S_WAIT`; it is 0 in every other state.
- Reset values:
  - State `S_IDLE`, `grant` 0, `start` 0, `busy` 0, `vga_we` 0, `timeout_err` 0.
  - `owner` 0 and `last` 3, so engine 0 wins first after reset.
- Reset mid-operation: returns to `S_IDLE` on the next edge with `grant` 0. No `start` is reissued. The interrupted engine is responsible for its own reset.
- Simultaneous request and completion: a `req` arriving in the same cycle as `done[owner]` is not considered until `S_IDLE`.
- A requester that still holds `req` after its grant is treated as a fresh request. Round-robin guarantees that every other pending requester is served first.

## Timing
- Arbitration latency: `req[i]` high in `S_IDLE` at cycle t gives `grant[i]` and `start[i]` at t+1, then `S_WAIT` from t+2.
- Release latency: `done` at cycle d gives `S_RELEASE` (`grant` 0) at d+1, `S_IDLE` at d+2, and the next `start` at d+3 at the earliest.
- Minimum overhead per job is 3 cycles beyond the engine's own run time.
- `start` is Moore-decoded from state. `vga_*` is a combinational mux; there is no pipeline register.

## Configuration
- `RENDER_ARB_TIMEOUT_EN` defined:
  - A 10-bit counter clears on entry to `S_WAIT` and increments each cycle spent there.
  - When it reaches `TIMEOUT_CYCLES` without `done[owner]`, the state goes to `S_RELEASE` and `timeout_err` is set to 1.
  - `timeout_err` is sticky until reset.
- `RENDER_ARB_TIMEOUT_EN` undefined: no counter is built, `S_WAIT` waits indefinitely, and `timeout_err` is constant 0.

## Test plan
- Single request, engine 1:
  - After reset, `req`=0010 at cycle 5 gives `grant`=0010 and `start`=0010 at cycle 6; `start`=0 at cycle 7.
  - Drive `eng_x` slice 1 = 36 and `eng_we[1]`=1: `vga_x`=36 and `vga_we`=1.
  - `done[1]` at cycle 20 gives `grant`=0 at 21 and `busy`=0 at 22.
- Simultaneous requests: `req`=1111 held, each engine pulsing `done` 10 cycles after its `start` and dropping its own `req` on seeing `start`. Grant order is 0001, 0010, 0100, 1000.
- Fairness: `req[0]` held permanently, `req[2]` raised while engine 0 owns the port. After `done[0]` the next grant is 0100, not 0001.
- Write gating:
  - `eng_we`=1111 with no request gives `vga_we`=0.
  - While engine 2 owns the port, `done[3]` and `eng_we[3]`=1 have no effect on `vga_we` or the state.
- Reset mid-job: assert `reset` for one cycle in `S_WAIT`. Next cycle `grant`=0, `busy`=0 and `start`=0; with `req`=1000 the first grant is 1000.
- Watchdog: with `RENDER_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, never pulse `done`. `timeout_err`=1 and `grant`=0 within 8 cycles of entering `S_WAIT`, and `timeout_err` stays 1 through later jobs.
